// File: rtl/treeval.sv
// treeval: decision-tree evaluator. It walks nodes N-1..0 once after each reset and folds
// weighted child values into per-action parent accumulators. Optional macro: TREEVAL_SAT_EN.
module treeval #(
  parameter int MAX_NODES = 64,
  parameter int W_ADDR    = 10,
  parameter int W_N_DATA  = 12,
  parameter int W_C_DATA  = 10,
  parameter int W_REWARD  = 12,
  parameter int W_ACTION  = 3,
  parameter int W_ACC     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_par,
  input  logic                mem_rew,
  input  logic                mem_act,
  input  logic                mem_weight,
  input  logic [W_ADDR-1:0]   mem_addr,
  input  logic [W_N_DATA-1:0] mem_data,
  input  logic                conf_nodes,
  input  logic [W_C_DATA-1:0] conf_data,
  output logic                exp_change,
  output logic [W_REWARD-1:0] exp,
  output logic [W_ACTION-1:0] act
);

  localparam int N_ACT  = 1 << W_ACTION;
  localparam int W_IDX  = $clog2(MAX_NODES);
  localparam int W_PROD = W_N_DATA + 1 + W_REWARD;
  localparam int W_C    = W_PROD - 7;

`ifdef TREEVAL_SAT_EN
  localparam logic signed [W_C:0]     ACC_MAX = (W_C+1)'(2**(W_ACC-1) - 1);
  localparam logic signed [W_C:0]     ACC_MIN = ~ACC_MAX;
  localparam logic signed [W_ACC-1:0] REW_MAX = W_ACC'(2**(W_REWARD-1) - 1);
  localparam logic signed [W_ACC-1:0] REW_MIN = ~REW_MAX;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_e;

  logic [W_ADDR-1:0]   parent_mem [MAX_NODES];
  logic [W_REWARD-1:0] reward_mem [MAX_NODES];
  logic [W_ACTION-1:0] action_mem [MAX_NODES];
  logic [W_N_DATA-1:0] weight_mem [MAX_NODES];
  logic [W_C_DATA-1:0] n_q;

  logic signed [W_ACC-1:0]        acc_q [MAX_NODES][N_ACT];
  logic [MAX_NODES-1:0][N_ACT-1:0] vld_q;

  state_e                state_q, state_d;
  logic [W_IDX-1:0]      idx_q, idx_d;
  logic [W_REWARD-1:0]   exp_q, exp_d;
  logic [W_ACTION-1:0]   act_q, act_d;
  logic                  chg_q, chg_d;

  logic                  addr_ok;
  logic [W_IDX-1:0]      waddr;
  logic [W_C_DATA-1:0]   n_lim;
  logic [W_IDX-1:0]      start_idx;

  logic [N_ACT-1:0]           node_vld;
  logic [W_ACTION-1:0]        a_idx;
  logic signed [W_ACC-1:0]    best_val;
  logic [W_ACTION-1:0]        best_a;
  logic                       found;
  logic signed [W_REWARD-1:0] node_v;
  logic signed [W_PROD-1:0]   prod;
  logic signed [W_C-1:0]      contrib;
  logic signed [W_ACC-1:0]    c_acc;
  logic signed [W_ACC-1:0]    acc_old;
  logic signed [W_ACC-1:0]    acc_new;
  logic [W_IDX-1:0]           p_idx;
  logic [W_ACTION-1:0]        p_act;
  logic                       contrib_en;
  logic                       upd_en;

  function automatic logic signed [W_ACC-1:0] fit_acc(input logic signed [W_C:0] x);
`ifdef TREEVAL_SAT_EN
    if (x > ACC_MAX)      return W_ACC'(ACC_MAX);
    else if (x < ACC_MIN) return W_ACC'(ACC_MIN);
    else                  return W_ACC'(x);
`else
    return W_ACC'(x);
`endif
  endfunction

  function automatic logic signed [W_REWARD-1:0] fit_rew(input logic signed [W_ACC-1:0] x);
`ifdef TREEVAL_SAT_EN
    if (x > REW_MAX)      return W_REWARD'(REW_MAX);
    else if (x < REW_MIN) return W_REWARD'(REW_MIN);
    else                  return W_REWARD'(x);
`else
    return W_REWARD'(x);
`endif
  endfunction

  assign addr_ok = mem_addr < W_ADDR'(MAX_NODES);
  assign waddr   = mem_addr[W_IDX-1:0];

  // NOTE: tables, N and accumulators carry no reset; only the valid bits are cleared, and a
  // clear valid bit makes the next contribution overwrite whatever stale value an accumulator holds.
  always_ff @(posedge clk) begin
    if (addr_ok) begin
      if (mem_par)    parent_mem[waddr] <= mem_data[W_ADDR-1:0];
      if (mem_rew)    reward_mem[waddr] <= mem_data[W_REWARD-1:0];
      if (mem_act)    action_mem[waddr] <= mem_data[W_ACTION-1:0];
      if (mem_weight) weight_mem[waddr] <= mem_data;
    end
    if (conf_nodes) n_q <= conf_data;
    if (upd_en)     acc_q[p_idx][p_act] <= acc_new;
  end

  // A node count beyond the table depth is clamped so the walk never indexes past the tables.
  assign n_lim     = (n_q > W_C_DATA'(MAX_NODES)) ? W_C_DATA'(MAX_NODES) : n_q;
  assign start_idx = W_IDX'(n_lim - W_C_DATA'(1));

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    node_vld = vld_q[idx_q];
    best_val = '0;
    best_a   = '0;
    found    = 1'b0;
    a_idx    = '0;
    for (int a = 0; a < N_ACT; a++) begin
      a_idx = W_ACTION'(a);
      if (node_vld[a_idx] && (!found || acc_q[idx_q][a_idx] > best_val)) begin
        best_val = acc_q[idx_q][a_idx];
        best_a   = a_idx;
        found    = 1'b1;
      end
    end
    node_v  = found ? fit_rew(best_val) : reward_mem[idx_q];
    prod    = {{W_REWARD{1'b0}}, 1'b0, weight_mem[idx_q]} *
              {{(W_N_DATA+1){node_v[W_REWARD-1]}}, node_v};
    contrib = W_C'(prod >>> 7);
    c_acc   = fit_acc({contrib[W_C-1], contrib});

    p_idx      = parent_mem[idx_q][W_IDX-1:0];
    p_act      = action_mem[idx_q];
    contrib_en = (idx_q != '0) && (parent_mem[idx_q] < W_ADDR'(idx_q));
    acc_old    = acc_q[p_idx][p_act];
    acc_new    = vld_q[p_idx][p_act]
               ? fit_acc({{(W_C+1-W_ACC){acc_old[W_ACC-1]}}, acc_old} +
                         {{(W_C+1-W_ACC){c_acc[W_ACC-1]}}, c_acc})
               : c_acc;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    act_d   = act_q;
    chg_d   = chg_q;
    upd_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (n_q == '0) begin
          state_d = S_DONE;
          chg_d   = 1'b1;
        end else begin
          state_d = S_EVAL;
          idx_d   = start_idx;
        end
      end
      S_EVAL: begin
        upd_en = contrib_en;
        if (idx_q == '0) begin
          state_d = S_DONE;
          exp_d   = node_v;
          act_d   = best_a;
          chg_d   = 1'b1;
        end else begin
          idx_d = idx_q - W_IDX'(1);
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      act_q   <= '0;
      chg_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      act_q   <= act_d;
      chg_q   <= chg_d;
      if (upd_en) vld_q[p_idx][p_act] <= 1'b1;
    end
  end

  assign exp_change = chg_q;
  assign exp        = exp_q;
  assign act        = act_q;

endmodule

// File: tb/tb_treeval.sv
// Self-checking bench for treeval: expected results are queued at launch and popped when
// exp_change rises; latency, reset behaviour and saturation/wrap are checked along the way.
`timescale 1ns/1ps
module tb_treeval;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_par = 1'b0, mem_rew = 1'b0, mem_act = 1'b0, mem_weight = 1'b0;
  logic [9:0]  mem_addr = '0;
  logic [11:0] mem_data = '0;
  logic        conf_nodes = 1'b0;
  logic [9:0]  conf_data = '0;
  logic        exp_change;
  logic [11:0] exp;
  logic [2:0]  act;

  always #5 clk = ~clk;

  treeval dut (
    .clk(clk), .rst(rst),
    .mem_par(mem_par), .mem_rew(mem_rew), .mem_act(mem_act), .mem_weight(mem_weight),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .conf_nodes(conf_nodes), .conf_data(conf_data),
    .exp_change(exp_change), .exp(exp), .act(act)
  );

  typedef struct packed {
    logic [11:0] exp_v;
    logic [2:0]  act_v;
  } res_t;

  res_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic res_t mk(input int e, input int a);
    res_t r;
    r.exp_v = 12'(e);
    r.act_v = 3'(a);
    return r;
  endfunction

  task automatic wr(input logic p, input logic r, input logic a, input logic w,
                    input int addr, input int data);
    @(negedge clk);
    mem_par = p; mem_rew = r; mem_act = a; mem_weight = w;
    mem_addr = 10'(addr);
    mem_data = 12'(data);
    @(negedge clk);
    mem_par = 1'b0; mem_rew = 1'b0; mem_act = 1'b0; mem_weight = 1'b0;
  endtask

  task automatic node(input int addr, input int par, input int rew, input int a, input int wt);
    wr(1'b1, 1'b0, 1'b0, 1'b0, addr, par);
    wr(1'b0, 1'b1, 1'b0, 1'b0, addr, rew);
    wr(1'b0, 1'b0, 1'b1, 1'b0, addr, a);
    wr(1'b0, 1'b0, 1'b0, 1'b1, addr, wt);
  endtask

  task automatic set_n(input int n);
    @(negedge clk);
    conf_nodes = 1'b1;
    conf_data  = 10'(n);
    @(negedge clk);
    conf_nodes = 1'b0;
  endtask

  task automatic launch();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (exp_change !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic load_example();
    node(0, 0, 0, 0, 0);
    node(1, 0, 0, 1, 64);
    node(2, 0, -10, 1, 64);
    node(3, 0, 0, 0, 100);
    node(4, 1, 100, 1, 64);
    node(5, 1, -50, 1, 64);
    node(6, 1, 10, 0, 127);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (exp_change !== 1'b0) begin errors++; $display("FAIL reset_chg: got %b want 0", exp_change); end
    checks++; if (exp !== 12'd0) begin errors++; $display("FAIL reset_exp: got %0d want 0", $signed(exp)); end
    checks++; if (act !== 3'd0) begin errors++; $display("FAIL reset_act: got %0d want 0", act); end
  endtask

  task automatic test_example();
    int   cyc;
    res_t r;
    rst = 1'b1;
    load_example();
    set_n(7);
    sb.push_back(mk(7, 1));
    launch();
    wait_done(10, cyc);
    r = sb.pop_front();
    checks++; if (exp_change !== 1'b1) begin errors++; $display("FAIL example_done: timeout after %0d cycles", cyc); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL example_latency: got %0d want 8", cyc); end
    checks++; if (exp !== r.exp_v) begin errors++; $display("FAIL example_exp: got %0d want %0d", $signed(exp), $signed(r.exp_v)); end
    checks++; if (act !== r.act_v) begin errors++; $display("FAIL example_act: got %0d want %0d", act, r.act_v); end
  endtask

  task automatic test_mid_reset();
    int   cyc;
    res_t r;
    launch();
    repeat (3) @(negedge clk);
    checks++; if (exp_change !== 1'b0) begin errors++; $display("FAIL mid_busy_chg: got %b want 0", exp_change); end
    rst = 1'b1;
    sb.push_back(mk(7, 1));
    @(negedge clk);
    rst = 1'b0;
    wait_done(9, cyc);
    r = sb.pop_front();
    checks++; if (exp_change !== 1'b1) begin errors++; $display("FAIL mid_done: timeout after %0d cycles", cyc); end
    checks++; if (exp !== r.exp_v) begin errors++; $display("FAIL mid_exp: got %0d want %0d", $signed(exp), $signed(r.exp_v)); end
    checks++; if (act !== r.act_v) begin errors++; $display("FAIL mid_act: got %0d want %0d", act, r.act_v); end
  endtask

  task automatic test_single();
    int   cyc;
    res_t r;
    rst = 1'b1;
    wr(1'b0, 1'b1, 1'b0, 1'b0, 0, -5);
    wr(1'b0, 1'b1, 1'b0, 1'b0, 64, 33);
    set_n(1);
    sb.push_back(mk(-5, 0));
    launch();
    wait_done(4, cyc);
    r = sb.pop_front();
    checks++; if (cyc !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", cyc); end
    checks++; if (exp !== r.exp_v) begin errors++; $display("FAIL single_exp: got %0d want %0d", $signed(exp), $signed(r.exp_v)); end
    checks++; if (act !== r.act_v) begin errors++; $display("FAIL single_act: got %0d want %0d", act, r.act_v); end
  endtask

  task automatic test_empty();
    int   cyc;
    res_t r;
    rst = 1'b1;
    set_n(0);
    sb.push_back(mk(0, 0));
    launch();
    wait_done(3, cyc);
    r = sb.pop_front();
    checks++; if (exp_change !== 1'b1 || cyc !== 1) begin errors++; $display("FAIL empty_done: chg %b after %0d cycles want 1 after 1", exp_change, cyc); end
    checks++; if (exp !== r.exp_v || act !== r.act_v) begin errors++; $display("FAIL empty_out: got exp %0d act %0d want 0 0", $signed(exp), act); end
  endtask

  task automatic test_tie();
    int   cyc;
    res_t r;
    rst = 1'b1;
    node(1, 0, 20, 2, 128);
    node(2, 0, 20, 1, 128);
    set_n(3);
    sb.push_back(mk(20, 1));
    launch();
    wait_done(6, cyc);
    r = sb.pop_front();
    checks++; if (exp_change !== 1'b1) begin errors++; $display("FAIL tie_done: timeout after %0d cycles", cyc); end
    checks++; if (exp !== r.exp_v) begin errors++; $display("FAIL tie_exp: got %0d want %0d", $signed(exp), $signed(r.exp_v)); end
    checks++; if (act !== r.act_v) begin errors++; $display("FAIL tie_act: got %0d want %0d", act, r.act_v); end
  endtask

  task automatic test_floor();
    int   cyc;
    res_t r;
    rst = 1'b1;
    node(1, 0, -3, 3, 100);
    set_n(2);
    sb.push_back(mk(-3, 3));
    launch();
    wait_done(5, cyc);
    r = sb.pop_front();
    checks++; if (exp !== r.exp_v) begin errors++; $display("FAIL floor_exp: got %0d want %0d", $signed(exp), $signed(r.exp_v)); end
    checks++; if (act !== r.act_v) begin errors++; $display("FAIL floor_act: got %0d want %0d", act, r.act_v); end
  endtask

  task automatic test_sat();
    int   cyc;
    int   want;
    res_t r;
`ifdef TREEVAL_SAT_EN
    want = 2047;
`else
    want = -48;
`endif
    rst = 1'b1;
    wr(1'b1, 1'b0, 1'b1, 1'b0, 1, 0);
    wr(1'b0, 1'b1, 1'b0, 1'b0, 1, 2047);
    wr(1'b0, 1'b0, 1'b0, 1'b1, 1, 4095);
    set_n(2);
    sb.push_back(mk(want, 0));
    launch();
    wait_done(5, cyc);
    r = sb.pop_front();
    checks++; if (exp !== r.exp_v) begin errors++; $display("FAIL sat_exp: got %0d want %0d", $signed(exp), $signed(r.exp_v)); end
    checks++; if (act !== r.act_v) begin errors++; $display("FAIL sat_act: got %0d want %0d", act, r.act_v); end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    res_t r;
    repeat (3) @(negedge clk);
    checks++; if (exp_change !== 1'b1) begin errors++; $display("FAIL hold_chg: got %b want 1", exp_change); end
    rst = 1'b1;
    #1;
    checks++; if (exp_change !== 1'b0 || exp !== 12'd0 || act !== 3'd0) begin
      errors++; $display("FAIL async_clear: got chg %b exp %0d act %0d want 0 0 0", exp_change, $signed(exp), act);
    end
    sb.push_back(mk(-3, 3));
    @(negedge clk);
    rst = 1'b0;
    wait_done(5, cyc);
    r = sb.pop_front();
    checks++; if (exp_change !== 1'b1 || cyc !== 3) begin errors++; $display("FAIL rerun_done: chg %b after %0d cycles want 1 after 3", exp_change, cyc); end
    checks++; if (exp !== r.exp_v || act !== r.act_v) begin
      errors++; $display("FAIL rerun_out: got exp %0d act %0d want %0d %0d", $signed(exp), act, $signed(r.exp_v), r.act_v);
    end
  endtask

  initial begin
    test_reset();
    test_example();
    test_mid_reset();
    test_single();
    test_empty();
    test_tie();
    test_sat();
    test_floor();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
